// File: rtl/id_ex_stage_pkg.sv
// rtl/id_ex_stage_pkg.sv - shared encodings and constants for the ID/EX pipeline register
package id_ex_stage_pkg;

  localparam int DATA_W_DEF = 64;

  localparam logic [1:0] ALUOP_MEM = 2'b00;
  localparam logic [1:0] ALUOP_BR  = 2'b01;
  localparam logic [1:0] ALUOP_R   = 2'b10;

  typedef struct packed {
    logic [3:0] funct;
    logic [1:0] alu_op;
    logic       alu_src;
    logic       mem_read;
    logic       mem_write;
    logic       mem_to_reg;
    logic       reg_write;
    logic       branch;
  } ex_ctrl_t;

  // A bubble decodes as an add with no writeback and no memory access.
  localparam ex_ctrl_t BUBBLE_CTRL = '{funct: 4'b0000, alu_op: ALUOP_MEM, default: 1'b0};

endpackage

// File: rtl/id_ex_stage_load_use_detect.sv
// rtl/id_ex_stage_load_use_detect.sv - combinational load-use hazard detector
module load_use_detect (
  input  logic       ex_valid,
  input  logic       ex_mem_read,
  input  logic [4:0] ex_rd,
  input  logic       id_valid,
  input  logic [4:0] id_rs1,
  input  logic [4:0] id_rs2,
  output logic       hz
);

  // Both rs fields are compared whatever the format; a false stall only costs a cycle.
  assign hz = ex_valid & ex_mem_read & (ex_rd != 5'd0) & id_valid &
              ((ex_rd == id_rs1) | (ex_rd == id_rs2));

endmodule

// File: rtl/id_ex_stage.sv
// rtl/id_ex_stage.sv - ID/EX pipeline register with load-use stall and flush bubbles
module id_ex_stage
  import id_ex_stage_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              id_valid,
  input  logic [DATA_W-1:0] id_pc,
  input  logic [DATA_W-1:0] id_rs1_data,
  input  logic [DATA_W-1:0] id_rs2_data,
  input  logic [DATA_W-1:0] id_imm,
  input  logic [4:0]        id_rs1,
  input  logic [4:0]        id_rs2,
  input  logic [4:0]        id_rd,
  input  logic [3:0]        id_funct,
  input  logic [1:0]        id_alu_op,
  input  logic              id_alu_src,
  input  logic              id_mem_read,
  input  logic              id_mem_write,
  input  logic              id_mem_to_reg,
  input  logic              id_reg_write,
  input  logic              id_branch,
  input  logic              flush_in,
  output logic              ex_valid,
  output logic [DATA_W-1:0] ex_pc,
  output logic [DATA_W-1:0] ex_rs1_data,
  output logic [DATA_W-1:0] ex_rs2_data,
  output logic [DATA_W-1:0] ex_imm,
  output logic [4:0]        ex_rs1,
  output logic [4:0]        ex_rs2,
  output logic [4:0]        ex_rd,
  output logic [3:0]        ex_funct,
  output logic [1:0]        ex_alu_op,
  output logic              ex_alu_src,
  output logic              ex_mem_read,
  output logic              ex_mem_write,
  output logic              ex_mem_to_reg,
  output logic              ex_reg_write,
  output logic              ex_branch,
  output logic              stall_out,
  output logic [CNT_W-1:0]  bubble_count
);

  logic              hz;
  logic              valid_q;
  logic [DATA_W-1:0] pc_q, rs1_data_q, rs2_data_q, imm_q;
  logic [4:0]        rs1_q, rs2_q, rd_q;
  ex_ctrl_t          ctrl_q;
  ex_ctrl_t          id_ctrl;
  logic [CNT_W-1:0]  bubble_q;

  assign id_ctrl = '{funct:      id_funct,
                     alu_op:     id_alu_op,
                     alu_src:    id_alu_src,
                     mem_read:   id_mem_read,
                     mem_write:  id_mem_write,
                     mem_to_reg: id_mem_to_reg,
                     reg_write:  id_reg_write,
                     branch:     id_branch};

  load_use_detect u_load_use_detect (
    .ex_valid    (valid_q),
    .ex_mem_read (ctrl_q.mem_read),
    .ex_rd       (rd_q),
    .id_valid    (id_valid),
    .id_rs1      (id_rs1),
    .id_rs2      (id_rs2),
    .hz          (hz)
  );

  // A flush kills the ID instruction, so there is nothing left to hold.
  assign stall_out = hz & ~flush_in;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q    <= 1'b0;
      pc_q       <= '0;
      rs1_data_q <= '0;
      rs2_data_q <= '0;
      imm_q      <= '0;
      rs1_q      <= '0;
      rs2_q      <= '0;
      rd_q       <= '0;
      ctrl_q     <= BUBBLE_CTRL;
    end else if (flush_in | hz) begin
      valid_q    <= 1'b0;
      pc_q       <= '0;
      rs1_data_q <= '0;
      rs2_data_q <= '0;
      imm_q      <= '0;
      rs1_q      <= '0;
      rs2_q      <= '0;
      rd_q       <= '0;
      ctrl_q     <= BUBBLE_CTRL;
    end else begin
      valid_q    <= id_valid;
      pc_q       <= id_pc;
      rs1_data_q <= id_rs1_data;
      rs2_data_q <= id_rs2_data;
      imm_q      <= id_imm;
      rs1_q      <= id_rs1;
      rs2_q      <= id_rs2;
      rd_q       <= id_rd;
      ctrl_q     <= id_ctrl;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bubble_q <= '0;
    end else if (stall_out) begin
      bubble_q <= bubble_q + CNT_W'(1);
    end
  end

  assign ex_valid      = valid_q;
  assign ex_pc         = pc_q;
  assign ex_rs1_data   = rs1_data_q;
  assign ex_rs2_data   = rs2_data_q;
  assign ex_imm        = imm_q;
  assign ex_rs1        = rs1_q;
  assign ex_rs2        = rs2_q;
  assign ex_rd         = rd_q;
  assign ex_funct      = ctrl_q.funct;
  assign ex_alu_op     = ctrl_q.alu_op;
  assign ex_alu_src    = ctrl_q.alu_src;
  assign ex_mem_read   = ctrl_q.mem_read;
  assign ex_mem_write  = ctrl_q.mem_write;
  assign ex_mem_to_reg = ctrl_q.mem_to_reg;
  assign ex_reg_write  = ctrl_q.reg_write;
  assign ex_branch     = ctrl_q.branch;
  assign bubble_count  = bubble_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// tb/tb_id_ex_stage.sv - directed self-checking bench for id_ex_stage
module tb_id_ex_stage;
  import id_ex_stage_pkg::*;

  localparam int DW = 64;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          id_valid;
  logic [DW-1:0] id_pc, id_rs1_data, id_rs2_data, id_imm;
  logic [4:0]    id_rs1, id_rs2, id_rd;
  logic [3:0]    id_funct;
  logic [1:0]    id_alu_op;
  logic          id_alu_src, id_mem_read, id_mem_write, id_mem_to_reg, id_reg_write, id_branch;
  logic          flush_in;
  logic          ex_valid;
  logic [DW-1:0] ex_pc, ex_rs1_data, ex_rs2_data, ex_imm;
  logic [4:0]    ex_rs1, ex_rs2, ex_rd;
  logic [3:0]    ex_funct;
  logic [1:0]    ex_alu_op;
  logic          ex_alu_src, ex_mem_read, ex_mem_write, ex_mem_to_reg, ex_reg_write, ex_branch;
  logic          stall_out;
  logic [CW-1:0] bubble_count;

  int pass_cnt = 0;
  int total_cnt = 0;
  logic [CW-1:0] exp_bc;

  // {valid, funct, alu_op, alu_src, mem_read, mem_write, mem_to_reg, reg_write, branch}
  logic [12:0] ex_ctl;
  assign ex_ctl = {ex_valid, ex_funct, ex_alu_op, ex_alu_src, ex_mem_read, ex_mem_write,
                   ex_mem_to_reg, ex_reg_write, ex_branch};
  logic [DW*4+15-1:0] ex_dat;
  assign ex_dat = {ex_pc, ex_rs1_data, ex_rs2_data, ex_imm, ex_rs1, ex_rs2, ex_rd};

  id_ex_stage #(.DATA_W(DW), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_pc(id_pc),
    .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data), .id_imm(id_imm),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd), .id_funct(id_funct),
    .id_alu_op(id_alu_op), .id_alu_src(id_alu_src), .id_mem_read(id_mem_read),
    .id_mem_write(id_mem_write), .id_mem_to_reg(id_mem_to_reg),
    .id_reg_write(id_reg_write), .id_branch(id_branch), .flush_in(flush_in),
    .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_rs1_data(ex_rs1_data),
    .ex_rs2_data(ex_rs2_data), .ex_imm(ex_imm), .ex_rs1(ex_rs1), .ex_rs2(ex_rs2),
    .ex_rd(ex_rd), .ex_funct(ex_funct), .ex_alu_op(ex_alu_op), .ex_alu_src(ex_alu_src),
    .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write),
    .ex_mem_to_reg(ex_mem_to_reg), .ex_reg_write(ex_reg_write), .ex_branch(ex_branch),
    .stall_out(stall_out), .bubble_count(bubble_count)
  );

  always #5 clk = ~clk;

  task automatic set_id(input logic v, input logic [4:0] rs1, input logic [4:0] rs2,
                        input logic [4:0] rd, input logic [3:0] funct, input logic [1:0] op,
                        input logic src, input logic mr, input logic mw, input logic m2r,
                        input logic rw, input logic br);
    id_valid = v; id_rs1 = rs1; id_rs2 = rs2; id_rd = rd; id_funct = funct;
    id_alu_op = op; id_alu_src = src; id_mem_read = mr; id_mem_write = mw;
    id_mem_to_reg = m2r; id_reg_write = rw; id_branch = br;
    id_pc       = 64'h0000_0000_0000_1000 + {59'd0, rd};
    id_rs1_data = 64'hA5A5_0000_0000_0000 | {59'd0, rs1};
    id_rs2_data = 64'h5A5A_0000_0000_0000 | {59'd0, rs2};
    id_imm      = 64'hFFFF_FFFF_FFFF_FF00 | {59'd0, rd};
  endtask

  task automatic set_ld(input logic [4:0] rs1, input logic [4:0] rd);
    set_id(1'b1, rs1, 5'd0, rd, 4'b0011, ALUOP_MEM, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
  endtask

  task automatic set_add(input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd);
    set_id(1'b1, rs1, rs2, rd, 4'b0000, ALUOP_R, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    set_add(5'd3, 5'd4, 5'd9);
    flush_in = 1'b0;
    #1 rst_n = 1'b0;
    #1;
    total_cnt++;
    if (ex_ctl !== 13'd0 || ex_dat !== '0) $display("FAIL reset_ex: ctl=%h dat=%h required 0", ex_ctl, ex_dat);
    else pass_cnt++;
    total_cnt++;
    if (bubble_count !== 4'd0 || stall_out !== 1'b0)
      $display("FAIL reset_cnt_stall: cnt=%0d stall=%b required 0/0", bubble_count, stall_out);
    else pass_cnt++;
    @(negedge clk) rst_n = 1'b1;
    exp_bc = 4'd0;
  endtask

  task automatic test_pass_through();
    @(negedge clk);
    set_id(1'b1, 5'd1, 5'd2, 5'd5, 4'b1000, ALUOP_R, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    #1;
    total_cnt++;
    if (stall_out !== 1'b0) $display("FAIL pass_stall: got %b required 0", stall_out);
    else pass_cnt++;
    tick();
    total_cnt++;
    if (ex_ctl !== 13'b1_1000_10_0_0_0_0_1_0) $display("FAIL pass_ctl: got %b required 1100010000010", ex_ctl);
    else pass_cnt++;
    total_cnt++;
    if (ex_rd !== 5'd5 || ex_rs1 !== 5'd1 || ex_rs2 !== 5'd2 || ex_pc !== 64'h1005 ||
        ex_rs1_data !== 64'hA5A5_0000_0000_0001 || ex_rs2_data !== 64'h5A5A_0000_0000_0002 ||
        ex_imm !== 64'hFFFF_FFFF_FFFF_FF05)
      $display("FAIL pass_data: got %h", ex_dat);
    else pass_cnt++;
    total_cnt++;
    if (stall_out !== 1'b0) $display("FAIL pass_stall_after: got %b required 0", stall_out);
    else pass_cnt++;
  endtask

  task automatic test_load_use();
    @(negedge clk) set_ld(5'd2, 5'd7);
    tick();
    @(negedge clk) set_add(5'd3, 5'd7, 5'd9);
    #1;
    total_cnt++;
    if (stall_out !== 1'b1) $display("FAIL lu_stall: got %b required 1", stall_out);
    else pass_cnt++;
    tick();
    exp_bc = exp_bc + 4'd1;
    total_cnt++;
    if (ex_ctl !== 13'd0 || ex_rd !== 5'd0) $display("FAIL lu_bubble: ctl=%b rd=%0d required 0/0", ex_ctl, ex_rd);
    else pass_cnt++;
    total_cnt++;
    if (bubble_count !== exp_bc) $display("FAIL lu_count: got %0d required %0d", bubble_count, exp_bc);
    else pass_cnt++;
    total_cnt++;
    if (stall_out !== 1'b0) $display("FAIL lu_stall_release: got %b required 0", stall_out);
    else pass_cnt++;
    tick();
    total_cnt++;
    if (ex_valid !== 1'b1 || ex_rd !== 5'd9 || ex_rs2 !== 5'd7 || ex_alu_op !== ALUOP_R || ex_reg_write !== 1'b1)
      $display("FAIL lu_held_add: valid=%b rd=%0d rs2=%0d op=%b required 1/9/7/10", ex_valid, ex_rd, ex_rs2, ex_alu_op);
    else pass_cnt++;
  endtask

  task automatic test_x0_exempt();
    @(negedge clk) set_ld(5'd1, 5'd0);
    tick();
    @(negedge clk) set_ld(5'd0, 5'd12);
    #1;
    total_cnt++;
    if (stall_out !== 1'b0) $display("FAIL x0_stall: got %b required 0", stall_out);
    else pass_cnt++;
    tick();
    total_cnt++;
    if (ex_valid !== 1'b1 || ex_rd !== 5'd12 || ex_mem_read !== 1'b1 || bubble_count !== exp_bc)
      $display("FAIL x0_load: valid=%b rd=%0d mr=%b cnt=%0d required 1/12/1/%0d",
               ex_valid, ex_rd, ex_mem_read, bubble_count, exp_bc);
    else pass_cnt++;
  endtask

  task automatic test_flush_priority();
    @(negedge clk) set_ld(5'd1, 5'd7);
    tick();
    @(negedge clk);
    set_add(5'd7, 5'd8, 5'd10);
    flush_in = 1'b1;
    #1;
    total_cnt++;
    if (stall_out !== 1'b0) $display("FAIL flush_stall: got %b required 0", stall_out);
    else pass_cnt++;
    tick();
    total_cnt++;
    if (ex_ctl !== 13'd0 || ex_dat !== '0) $display("FAIL flush_bubble: ctl=%b dat=%h required 0", ex_ctl, ex_dat);
    else pass_cnt++;
    total_cnt++;
    if (bubble_count !== exp_bc) $display("FAIL flush_count: got %0d required %0d", bubble_count, exp_bc);
    else pass_cnt++;
    @(negedge clk) set_add(5'd3, 5'd4, 5'd11);
    tick();
    total_cnt++;
    if (ex_ctl !== 13'd0 || bubble_count !== exp_bc)
      $display("FAIL flush_only: ctl=%b cnt=%0d required 0/%0d", ex_ctl, bubble_count, exp_bc);
    else pass_cnt++;
    @(negedge clk) flush_in = 1'b0;
  endtask

  task automatic test_back_to_back();
    logic [4:0] stall_seq;
    stall_seq = '0;
    @(negedge clk) set_ld(5'd1, 5'd5);
    tick();
    @(negedge clk) set_ld(5'd5, 5'd6);
    #1 stall_seq[4] = stall_out;
    tick();
    #0 stall_seq[3] = stall_out;
    tick();
    @(negedge clk) set_add(5'd2, 5'd6, 5'd13);
    #1 stall_seq[2] = stall_out;
    tick();
    stall_seq[1] = stall_out;
    tick();
    stall_seq[0] = stall_out;
    exp_bc = exp_bc + 4'd2;
    total_cnt++;
    if (stall_seq !== 5'b10100) $display("FAIL b2b_stalls: got %b required 10100", stall_seq);
    else pass_cnt++;
    total_cnt++;
    if (ex_rd !== 5'd13 || ex_rs2 !== 5'd6 || bubble_count !== exp_bc)
      $display("FAIL b2b_final: rd=%0d rs2=%0d cnt=%0d required 13/6/%0d", ex_rd, ex_rs2, bubble_count, exp_bc);
    else pass_cnt++;
  endtask

  task automatic test_mid_stall_reset();
    @(negedge clk) set_ld(5'd1, 5'd8);
    tick();
    @(negedge clk) set_add(5'd8, 5'd2, 5'd14);
    #2 rst_n = 1'b0;
    #1;
    total_cnt++;
    if (ex_ctl !== 13'd0 || ex_dat !== '0 || bubble_count !== 4'd0 || stall_out !== 1'b0)
      $display("FAIL midreset: ctl=%b cnt=%0d stall=%b required 0/0/0", ex_ctl, bubble_count, stall_out);
    else pass_cnt++;
    @(negedge clk) rst_n = 1'b1;
    exp_bc = 4'd0;
    tick();
    total_cnt++;
    if (ex_valid !== 1'b1 || ex_rd !== 5'd14 || ex_rs1 !== 5'd8 || bubble_count !== 4'd0)
      $display("FAIL midreset_release: valid=%b rd=%0d cnt=%0d required 1/14/0", ex_valid, ex_rd, bubble_count);
    else pass_cnt++;
  endtask

  task automatic test_counter_wrap();
    for (int i = 0; i < 16; i++) begin
      @(negedge clk) set_ld(5'd0, 5'd7);
      tick();
      @(negedge clk) set_add(5'd7, 5'd0, 5'd15);
      tick();
      tick();
      if (i == 14) begin
        total_cnt++;
        if (bubble_count !== 4'd15) $display("FAIL wrap_15: got %0d required 15", bubble_count);
        else pass_cnt++;
      end
    end
    total_cnt++;
    if (bubble_count !== 4'd0) $display("FAIL wrap_0: got %0d required 0", bubble_count);
    else pass_cnt++;
  endtask

  initial begin
    flush_in = 1'b0;
    set_id(1'b0, 5'd0, 5'd0, 5'd0, 4'd0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    test_reset();
    test_pass_through();
    test_load_use();
    test_x0_exempt();
    test_flush_priority();
    test_back_to_back();
    test_mid_stall_reset();
    test_counter_wrap();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
